msg_sequencer: RTL and testbench
================================

MSG_SEQUENCER -- requirements
Module: msg_sequencer

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- MSG_LEN, 8, number of 4-bit message entries.
- MSG, 32'h8765_4310, packed message; entry k occupies bits [4k+3:4k].
- TICK_DIV, 50_000_000, clk cycles per advance.
- BLANK, 4'hF, code driven while idle.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, sole clock, rising edge.
- rst, in, 1, asynchronous active-high reset.
- start, in, 1, begin or restart the message.
- pause, in, 1, freeze the current entry.
- stop, in, 1, return to idle.
- x3, x2, x1, x0, out, 1 each, current code MSB..LSB; feeds the 7-segment letter decoder directly.
- pos, out, max(1,clog2(MSG_LEN)), current entry index.
- wrap, out, 1, one-cycle pulse on index wrap.
- running, out, 1, high in RUN.

Function
REQ-003 The FSM SHALL have states IDLE, RUN and PAUSE; control priority SHALL be stop > start > pause.
REQ-004 The FSM SHALL make these transitions:
- stop in any state goes to IDLE.
- start in any state goes to RUN, with pos=0 and prescaler=0.
- pause in RUN goes to PAUSE.
- start in PAUSE resumes RUN with pos and prescaler unchanged.
REQ-005 In RUN, the prescaler SHALL count 0..TICK_DIV-1; at TICK_DIV-1 it SHALL return to 0 and generate an internal tick.
REQ-006 On a tick, pos SHALL advance by 1; from MSG_LEN-1 it SHALL wrap to 0 and assert wrap for exactly that one cycle.
REQ-007 In PAUSE and IDLE, the prescaler and pos SHALL hold, and wrap SHALL stay 0.
REQ-008 If pause or stop coincides with a tick, pos SHALL NOT advance and wrap SHALL NOT pulse.
REQ-009 {x3,x2,x1,x0} SHALL be registered:
- In RUN or PAUSE, they equal MSG entry pos.
- In IDLE, they equal BLANK.
- They change on the same edge as pos and state; latency from a control input is 1 clk.
REQ-010 Entering IDLE via stop SHALL reset pos to 0.
REQ-011 TICK_DIV=1 SHALL advance pos every RUN cycle; MSG_LEN=1 SHALL pulse wrap on every tick with pos fixed at 0.

Reset
REQ-012 While rst=1, the outputs SHALL be: state=IDLE, prescaler=0, pos=0, wrap=0, running=0, {x3..x0}=BLANK.
REQ-013 rst asserted mid-operation SHALL take effect immediately and asynchronously; after release, the block SHALL wait in IDLE for start.

Configuration
REQ-014 With macro MSG_SEQUENCER_REVERSE_EN defined:
- The block SHALL add input dir (1 bit).
- dir=0 SHALL increment pos.
- dir=1 SHALL decrement pos, wrapping 0 to MSG_LEN-1 with a wrap pulse.
- dir is sampled only on tick cycles.
REQ-015 Without MSG_SEQUENCER_REVERSE_EN, the dir port SHALL be absent and pos SHALL always increment.

Verification (TICK_DIV=4, MSG_LEN=4, MSG=16'h3210, BLANK=F)
REQ-016 Reset release, then no start -> code F, pos 0, running 0, held indefinitely.
REQ-017 start pulse -> next edge: code 0, running 1; codes 1,2,3 each 4 cycles later; then code 0, pos 0, wrap high one cycle.
REQ-018 pause at pos 2 held 10 cycles, then start -> code 2 holds throughout; advance to 3 occurs after the remaining prescaler count, not a full 4 cycles.
REQ-019 start, pause and stop asserted together in RUN -> IDLE, code F, pos 0; start together with pause from PAUSE -> RUN at pos 0.
REQ-020 rst pulsed mid-cycle at pos 3 -> outputs go to F/0/0 before the next clk edge; with REVERSE_EN, dir=1 from pos 0 -> pos 3, wrap pulse.

Source files
------------

// File: rtl/msg_sequencer.sv
// Message sequencer: steps through packed 4-bit codes at a prescaled rate under start/pause/stop control.
// Optional macro MSG_SEQUENCER_REVERSE_EN adds a dir input that selects decrementing playback.
module msg_sequencer #(
    parameter int unsigned          MSG_LEN  = 8,
    parameter logic [4*MSG_LEN-1:0] MSG      = 32'h8765_4310,
    parameter int unsigned          TICK_DIV = 50_000_000,
    parameter logic [3:0]           BLANK    = 4'hF
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic pause,
    input  logic stop,
`ifdef MSG_SEQUENCER_REVERSE_EN
    input  logic dir,
`endif
    output logic x3,
    output logic x2,
    output logic x1,
    output logic x0,
    output logic [((MSG_LEN > 1) ? $clog2(MSG_LEN) : 1)-1:0] pos,
    output logic wrap,
    output logic running
);
    localparam int PW = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] POS_LAST = PW'(MSG_LEN - 1);
    localparam logic [CW-1:0] PRE_LAST = CW'(TICK_DIV - 1);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] presc_q, presc_d;
    logic [PW-1:0] pos_q, pos_d;
    logic [3:0]    code_q, code_d;
    logic          wrap_q, wrap_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            presc_q <= '0;
            pos_q   <= '0;
            code_q  <= BLANK;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            pos_q   <= pos_d;
            code_q  <= code_d;
            wrap_q  <= wrap_d;
        end
    end

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        pos_d   = pos_q;
        wrap_d  = 1'b0;
        if (stop) begin
            state_d = IDLE;
            presc_d = '0;
            pos_d   = '0;
        end else if (start) begin
            state_d = RUN;
            // start alone from PAUSE resumes; any other start restarts the message
            if (!(state_q == PAUSE && !pause)) begin
                presc_d = '0;
                pos_d   = '0;
            end
        end else if (pause) begin
            if (state_q == RUN) state_d = PAUSE;
        end else if (state_q == RUN) begin
            if (presc_q == PRE_LAST) begin
                presc_d = '0;
`ifdef MSG_SEQUENCER_REVERSE_EN
                if (dir) begin
                    pos_d  = (pos_q == '0) ? POS_LAST : pos_q - PW'(1);
                    wrap_d = (pos_q == '0);
                end else
`endif
                begin
                    pos_d  = (pos_q == POS_LAST) ? '0 : pos_q + PW'(1);
                    wrap_d = (pos_q == POS_LAST);
                end
            end else begin
                presc_d = presc_q + CW'(1);
            end
        end
        code_d = (state_d == IDLE) ? BLANK : MSG[{pos_d, 2'b00} +: 4];
    end

    assign {x3, x2, x1, x0} = code_q;
    assign pos     = pos_q;
    assign wrap    = wrap_q;
    assign running = (state_q == RUN);
endmodule

// File: tb/tb_msg_sequencer.sv
// Bench for msg_sequencer: directed vector table plus randomized control against an elapsed-time reference model.
module tb_msg_sequencer;
    logic clk = 1'b0;
    logic rst, start, pause, stop;
`ifdef MSG_SEQUENCER_REVERSE_EN
    logic dir = 1'b0;
`endif
    logic       ax3, ax2, ax1, ax0, awrap, arun;
    logic [1:0] apos;
    logic       bx3, bx2, bx1, bx0, bwrap, brun;
    logic [2:0] bpos;
    logic       cx3, cx2, cx1, cx0, cwrap, crun;
    logic [0:0] cpos;

    int errors = 0;
    int checks = 0;
    bit model_on = 1'b1;

    msg_sequencer #(.MSG_LEN(4), .MSG(16'h3210), .TICK_DIV(4), .BLANK(4'hF)) dut_a (
        .clk(clk), .rst(rst), .start(start), .pause(pause), .stop(stop),
`ifdef MSG_SEQUENCER_REVERSE_EN
        .dir(dir),
`endif
        .x3(ax3), .x2(ax2), .x1(ax1), .x0(ax0), .pos(apos), .wrap(awrap), .running(arun));

    msg_sequencer #(.MSG_LEN(5), .MSG(20'hB47C9), .TICK_DIV(3), .BLANK(4'hE)) dut_b (
        .clk(clk), .rst(rst), .start(start), .pause(pause), .stop(stop),
`ifdef MSG_SEQUENCER_REVERSE_EN
        .dir(dir),
`endif
        .x3(bx3), .x2(bx2), .x1(bx1), .x0(bx0), .pos(bpos), .wrap(bwrap), .running(brun));

    msg_sequencer #(.MSG_LEN(1), .MSG(4'h7), .TICK_DIV(1), .BLANK(4'hF)) dut_c (
        .clk(clk), .rst(rst), .start(start), .pause(pause), .stop(stop),
`ifdef MSG_SEQUENCER_REVERSE_EN
        .dir(dir),
`endif
        .x3(cx3), .x2(cx2), .x1(cx1), .x0(cx0), .pos(cpos), .wrap(cwrap), .running(crun));

    initial forever #5 clk = ~clk;

    // Reference model: a run-time counter that only grows on uninterrupted RUN cycles.
    int          mlen [3] = '{4, 5, 1};
    int          tdiv [3] = '{4, 3, 1};
    logic [31:0] mmsg [3] = '{32'h3210, 32'hB47C9, 32'h7};
    logic [3:0]  mblnk[3] = '{4'hF, 4'hE, 4'hF};
    int          mode [3];   // 0 idle, 1 run, 2 pause
    longint      el   [3];
    logic        mwrap[3];

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            mode[i] = 0; el[i] = 0; mwrap[i] = 1'b0;
        end
    endtask

    task automatic model_step(input logic st, input logic pa, input logic sp);
        for (int i = 0; i < 3; i++) begin
            mwrap[i] = 1'b0;
            if (sp) begin
                mode[i] = 0; el[i] = 0;
            end else if (st) begin
                if (!(mode[i] == 2 && !pa)) el[i] = 0;
                mode[i] = 1;
            end else if (pa) begin
                if (mode[i] == 1) mode[i] = 2;
            end else if (mode[i] == 1) begin
                el[i]++;
                if (el[i] % (tdiv[i] * mlen[i]) == 0) mwrap[i] = 1'b1;
            end
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic get_out(input int i, output logic [3:0] code, output logic [2:0] p,
                           output logic w, output logic r);
        case (i)
            0: begin code = {ax3, ax2, ax1, ax0}; p = {1'b0, apos}; w = awrap; r = arun; end
            1: begin code = {bx3, bx2, bx1, bx0}; p = bpos; w = bwrap; r = brun; end
            default: begin code = {cx3, cx2, cx1, cx0}; p = {2'b00, cpos}; w = cwrap; r = crun; end
        endcase
    endtask

    task automatic check_models(input string tag);
        logic [3:0] code;
        logic [2:0] p;
        logic       w, r;
        int         ep;
        logic [3:0] ecode;
        for (int i = 0; i < 3; i++) begin
            get_out(i, code, p, w, r);
            ep = int'((el[i] / tdiv[i]) % mlen[i]);
            ecode = (mode[i] == 0) ? mblnk[i] : mmsg[i][4*ep +: 4];
            chk($sformatf("%s dut%0d code", tag, i), {28'd0, code}, {28'd0, ecode});
            chk($sformatf("%s dut%0d pos", tag, i), {29'd0, p}, ep);
            chk($sformatf("%s dut%0d wrap", tag, i), {31'd0, w}, {31'd0, mwrap[i]});
            chk($sformatf("%s dut%0d running", tag, i), {31'd0, r}, {31'd0, mode[i] == 1});
        end
    endtask

    task automatic step(input logic st, input logic pa, input logic sp, input string tag);
        start = st; pause = pa; stop = sp;
        @(posedge clk);
        model_step(st, pa, sp);
        #1;
        if (model_on) check_models(tag);
        start = 1'b0; pause = 1'b0; stop = 1'b0;
    endtask

    typedef struct {
        logic       st, pa, sp;
        logic [3:0] code;
        logic [1:0] p;
        logic       w, r;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input logic st, input logic pa, input logic sp, input logic [3:0] code,
                       input logic [1:0] p, input logic w, input logic r);
        vec_t v;
        v.st = st; v.pa = pa; v.sp = sp; v.code = code; v.p = p; v.w = w; v.r = r;
        tbl.push_back(v);
    endtask

    initial begin
        // idle after reset, then one full message pass
        for (int k = 0; k < 5; k++) add(0, 0, 0, 4'hF, 2'd0, 0, 0);
        add(1, 0, 0, 4'h0, 2'd0, 0, 1);
        for (int k = 1; k <= 26; k++) add(0, 0, 0, 4'((k / 4) % 4), 2'((k / 4) % 4), k == 16, 1);
        // pause at pos 2 for 10 cycles, resume finishes the partial prescaler count
        for (int k = 0; k < 10; k++) add(0, 1, 0, 4'h2, 2'd2, 0, 0);
        add(1, 0, 0, 4'h2, 2'd2, 0, 1);
        add(0, 0, 0, 4'h2, 2'd2, 0, 1);
        add(0, 0, 0, 4'h3, 2'd3, 0, 1);
        // all controls at once, pause in idle, start+pause from PAUSE restarts
        add(1, 1, 1, 4'hF, 2'd0, 0, 0);
        add(0, 1, 0, 4'hF, 2'd0, 0, 0);
        add(0, 0, 0, 4'hF, 2'd0, 0, 0);
        add(1, 0, 0, 4'h0, 2'd0, 0, 1);
        add(0, 0, 0, 4'h0, 2'd0, 0, 1);
        add(0, 1, 0, 4'h0, 2'd0, 0, 0);
        add(1, 1, 0, 4'h0, 2'd0, 0, 1);
        for (int k = 0; k < 3; k++) add(0, 0, 0, 4'h0, 2'd0, 0, 1);
        add(0, 0, 0, 4'h1, 2'd1, 0, 1);
        // pause and then stop landing exactly on a tick
        for (int k = 0; k < 3; k++) add(0, 0, 0, 4'h1, 2'd1, 0, 1);
        add(0, 1, 0, 4'h1, 2'd1, 0, 0);
        add(1, 0, 0, 4'h1, 2'd1, 0, 1);
        add(0, 0, 0, 4'h2, 2'd2, 0, 1);
        for (int k = 0; k < 3; k++) add(0, 0, 0, 4'h2, 2'd2, 0, 1);
        add(0, 0, 1, 4'hF, 2'd0, 0, 0);

        rst = 1'b1; start = 1'b0; pause = 1'b0; stop = 1'b0;
        model_reset();
        #2;
        check_models("reset_async");
        repeat (2) @(posedge clk);
        #1;
        check_models("reset_held");
        @(negedge clk);
        rst = 1'b0;

        foreach (tbl[r]) begin
            step(tbl[r].st, tbl[r].pa, tbl[r].sp, $sformatf("tbl%0d", r));
            chk($sformatf("tbl%0d code", r), {28'd0, ax3, ax2, ax1, ax0}, {28'd0, tbl[r].code});
            chk($sformatf("tbl%0d pos", r), {30'd0, apos}, {30'd0, tbl[r].p});
            chk($sformatf("tbl%0d wrap", r), {31'd0, awrap}, {31'd0, tbl[r].w});
            chk($sformatf("tbl%0d running", r), {31'd0, arun}, {31'd0, tbl[r].r});
        end

        // asynchronous reset in the middle of a cycle at pos 3
        step(1, 0, 0, "pre_rst");
        for (int k = 0; k < 12; k++) step(0, 0, 0, "pre_rst");
        chk("pre_rst pos3", {30'd0, apos}, 32'd3);
        #3 rst = 1'b1;
        model_reset();
        #1;
        chk("midrst code", {28'd0, ax3, ax2, ax1, ax0}, 32'hF);
        chk("midrst pos", {30'd0, apos}, 32'd0);
        chk("midrst running", {31'd0, arun}, 32'd0);
        check_models("midrst");
        #2 rst = 1'b0;
        for (int k = 0; k < 4; k++) step(0, 0, 0, "post_rst_idle");

`ifdef MSG_SEQUENCER_REVERSE_EN
        model_on = 1'b0;
        dir = 1'b1;
        step(1, 0, 0, "rev");
        for (int k = 0; k < 3; k++) step(0, 0, 0, "rev");
        chk("rev pos before tick", {30'd0, apos}, 32'd0);
        step(0, 0, 0, "rev");
        chk("rev pos wrap to 3", {30'd0, apos}, 32'd3);
        chk("rev wrap pulse", {31'd0, awrap}, 32'd1);
        chk("rev code", {28'd0, ax3, ax2, ax1, ax0}, 32'h3);
        dir = 1'b0;
        step(0, 0, 1, "rev_stop");
        model_on = 1'b1;
        step(0, 0, 0, "rev_resync");
`endif

        for (int n = 0; n < 3000; n++) begin
            step($urandom_range(99) < 4, $urandom_range(99) < 7, $urandom_range(99) < 2,
                 $sformatf("rnd%0d", n));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
